spi_read_cache: RTL
===================

# spi_read_cache

Direct-mapped, write-through read cache between `cpu_top`'s memory port and `spi_memory_controller`. It caches 16-bit read words, forwards all writes downstream, and invalidates overlapping entries on writes. Read hits complete in 1 cycle instead of a full SPI transaction. It is transparent to both neighbours: the same req/ready protocol is used on both sides.

## Interface
- `LINES`, 16: number of cache entries (power of 2, ≥4); `IDX_W = $clog2(LINES)`
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `cpu_req`  in  1  CPU request; holds `cpu_addr`/`cpu_we`/`cpu_wdata` stable until `cpu_ready`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  16  byte address
- `cpu_wdata`  in  16  write word
- `cpu_rdata`  out  16  read word, valid while `cpu_ready`=1
- `cpu_ready`  out  1  one-cycle completion pulse
- `ds_req`, `ds_we`, `ds_addr[15:0]`, `ds_wdata[15:0]`  out  downstream request to SPI controller, same rules as the CPU side
- `ds_rdata`  in  16  downstream read word
- `ds_ready`  in  1  downstream completion pulse
- `cache_en`  in  1  0 = bypass: every read is a miss with no fill
- `cache_flush`  in  1  pulse; clears all valid bits
- `hit_count`, `miss_count`  out  16  saturating statistics counters

## Operation
- Entry: `valid`, `tag = addr[15:IDX_W]`, 16-bit `data`; index = `addr[IDX_W-1:0]`.
- FSM states: IDLE, FETCH, WRITE, RESP.
- IDLE, `cpu_req`=1, read, `cache_en`=1, valid && tag match (hit):
  - latch `cpu_rdata` = entry data
  - go to RESP
  - `hit_count`++
- IDLE, read miss (or `cache_en`=0):
  - latch address, go to FETCH
  - `miss_count`++
- FETCH:
  - `ds_req`=1, `ds_we`=0, `ds_addr` = latched address
  - on `ds_ready`: capture `ds_rdata` into `cpu_rdata`; fill the entry if `cache_en`=1 and no flush occurred during FETCH; go to RESP
- IDLE, write:
  - latch addr/wdata
  - clear `valid` at indices of addr−1, addr, addr+1 (mod 2^16; all three words overlap the written bytes)
  - go to WRITE
- WRITE: `ds_req`=1, `ds_we`=1; on `ds_ready` go to RESP. Writes never allocate.
- RESP: `cpu_ready`=1 for exactly one cycle, then IDLE. The CPU deasserts `cpu_req` on the edge that samples `cpu_ready`, so `cpu_req`=1 in the next IDLE cycle is a new request.
- `cache_flush`:
  - clears all valid bits on the sampling edge, in any state
  - sets an internal `flushed` flag so an in-flight fill is discarded; the data is still returned to the CPU
- `cache_flush` and the write invalidate in the same cycle: all entries end up invalid.
- Counters saturate at 0xFFFF; `cache_flush` does not clear them.
- Reset state:
  - FSM IDLE, all valid=0
  - `cpu_ready`=0, `ds_req`=0, `ds_we`=0, `ds_addr`=0, `ds_wdata`=0, `cpu_rdata`=0
  - counters 0
- Reset mid-transaction: `ds_req` drops the cycle after reset is sampled. The abandoned downstream transfer is not tracked, and a late `ds_ready` in IDLE is ignored.

## Timing
- All outputs are registered.
- Read hit: `cpu_req` sampled at edge N, `cpu_ready`=1 during cycle N+1 (1-cycle latency).
- Read miss:
  - `ds_req`=1 from cycle N+1
  - `ds_ready` sampled at edge M
  - `cpu_ready` during cycle M+1
  - `ds_req` low from cycle M+1
- Write: same timing as a miss. The invalidate takes effect at edge N, so a read issued right after the write completes misses.
- `ds_ready` is ignored outside FETCH/WRITE.
- Throughput: at most one CPU transaction outstanding.

## Structure
- Package `neander_cache_pkg` holds:
  - `cache_state_t` enum (IDLE, FETCH, WRITE, RESP)
  - `ADDR_W`=16, `DATA_W`=16
  - counter saturation constant
- Sub-module `spi_cache_store`: valid/tag/data arrays with
  - combinational read port
  - one fill port
  - a 3-index invalidate port
  - a flush input
- The top holds the FSM, latches and counters. It is instantiated in `neander_tb_wrapper` between `cpu` and `spi_ctrl`.

## Test plan
- Read 0x0100 (SRAM 0x0100=0x34, 0x0101=0x12) twice:
  - first: miss, `cpu_rdata`=0x1234, `miss_count`=1
  - second: hit, `cpu_ready` 1 cycle after `cpu_req`, `hit_count`=1, no `ds_req`
- Read 0x0100, write 0xBEEF to 0x0101, read 0x0100 → second read misses, returns 0xEF34 (low byte 0x34 unchanged, 0x0101 now 0xEF).
- Conflict: `LINES`=16, read 0x0003 then 0x0013 then 0x0003 → three misses; the second fill of index 3 evicts the first.
- Write to 0xFFFF → valid cleared at indices for 0xFFFE, 0xFFFF, 0x0000; a previously cached 0x0000 misses on the next read.
- `cache_flush` pulsed mid-FETCH of 0x0200 → CPU gets the SRAM value, and a re-read of 0x0200 misses.
- `reset` asserted while FETCH `ds_req`=1:
  - next cycle `ds_req`=0, `cpu_ready`=0, counters 0
  - a late `ds_ready` produces no `cpu_ready`

Source files
------------

// File: rtl/spi_read_cache_pkg.sv
// Shared types and constants for the SPI read cache: FSM states, bus widths, counter saturation.
package neander_cache_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } cache_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_read_cache_if.sv
// req/ready memory port shared by the CPU side and the SPI controller side of the cache.
interface spi_read_cache_if;

    logic                                 req;
    logic                                 we;
    logic [neander_cache_pkg::ADDR_W-1:0] addr;
    logic [neander_cache_pkg::DATA_W-1:0] wdata;
    logic [neander_cache_pkg::DATA_W-1:0] rdata;
    logic                                 ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/spi_read_cache_store.sv
// Valid/tag/data arrays: combinational read, one fill port, 3-index invalidate, flush.
// Flush and invalidate take priority over a fill landing on the same edge.
module spi_cache_store
    import neander_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = ADDR_W - IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_vld,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_dat,
    input  logic                  fill_en,
    input  logic [IDX_W-1:0]      fill_idx,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [DATA_W-1:0]     fill_dat,
    input  logic                  inv_en,
    input  logic [2:0][IDX_W-1:0] inv_idx,
    input  logic                  flush
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [DATA_W-1:0] dat_mem [LINES];

    assign rd_vld = valid[rd_idx];
    assign rd_tag = tag_mem[rd_idx];
    assign rd_dat = dat_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= '0;
        end else begin
            if (fill_en) begin
                valid[fill_idx] <= 1'b1;
            end
            if (inv_en) begin
                for (int i = 0; i < 3; i++) begin
                    valid[inv_idx[i]] <= 1'b0;
                end
            end
        end
    end

    // Payload arrays need no reset; valid gates every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx] <= fill_tag;
            dat_mem[fill_idx] <= fill_dat;
        end
    end

endmodule

// File: rtl/spi_read_cache.sv
// Direct-mapped write-through read cache between the CPU port and the SPI memory controller.
// Read hit answers 1 cycle after the request; misses and writes wait for ds.ready; one transaction outstanding.
module spi_read_cache
    import neander_cache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic               clk,
    input  logic               reset,
    spi_read_cache_if.slave    cpu,
    spi_read_cache_if.master   ds,
    input  logic               cache_en,
    input  logic               cache_flush,
    output logic [DATA_W-1:0]  hit_count,
    output logic [DATA_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    cache_state_t state, state_nxt;

    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  ready_q;
    logic                  ds_req_q;
    logic                  ds_we_q;
    logic                  flushed;

    logic                  rd_vld;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_W-1:0]     rd_dat;
    logic [IDX_W-1:0]      cpu_idx;
    logic [2:0][IDX_W-1:0] inv_idx;

    logic                  accept;
    logic                  is_hit;
    logic                  inv_en;
    logic                  fill_en;

    assign cpu_idx = cpu.addr[IDX_W-1:0];
    // Words at addr-1, addr and addr+1 all overlap the two written bytes.
    assign inv_idx = {cpu_idx + IDX_W'(1), cpu_idx, cpu_idx - IDX_W'(1)};

    spi_cache_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (cpu_idx),
        .rd_vld   (rd_vld),
        .rd_tag   (rd_tag),
        .rd_dat   (rd_dat),
        .fill_en  (fill_en),
        .fill_idx (addr_q[IDX_W-1:0]),
        .fill_tag (addr_q[ADDR_W-1:IDX_W]),
        .fill_dat (ds.rdata),
        .inv_en   (inv_en),
        .inv_idx  (inv_idx),
        .flush    (cache_flush)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu.req) begin
                    if (cpu.we) begin
                        state_nxt = WRITE;
                    end else if (is_hit) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH, WRITE: begin
                if (ds.ready) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A flush seen any time during FETCH (including the ds.ready cycle) suppresses the fill.
    always_comb begin
        accept  = (state == IDLE) && cpu.req;
        is_hit  = accept && !cpu.we && cache_en && rd_vld
                  && (rd_tag == cpu.addr[ADDR_W-1:IDX_W]);
        inv_en  = accept && cpu.we;
        fill_en = (state == FETCH) && ds.ready && cache_en && !flushed && !cache_flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q    <= 1'b0;
            ds_req_q   <= 1'b0;
            ds_we_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            flushed    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            ready_q  <= (state_nxt == RESP);
            ds_req_q <= (state_nxt == FETCH) || (state_nxt == WRITE);
            ds_we_q  <= (state_nxt == WRITE);
            if (accept) begin
                addr_q  <= cpu.addr;
                wdata_q <= cpu.wdata;
            end
            if (is_hit) begin
                rdata_q <= rd_dat;
            end else if ((state == FETCH) && ds.ready) begin
                rdata_q <= ds.rdata;
            end
            if (state == IDLE) begin
                flushed <= 1'b0;
            end else if (cache_flush) begin
                flushed <= 1'b1;
            end
            if (is_hit) begin
                hit_count <= sat_inc(hit_count);
            end
            if (accept && !cpu.we && !is_hit) begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end

    assign cpu.ready = ready_q;
    assign cpu.rdata = rdata_q;
    assign ds.req    = ds_req_q;
    assign ds.we     = ds_we_q;
    assign ds.addr   = addr_q;
    assign ds.wdata  = wdata_q;

endmodule
